// File: rtl/a5_pkg.sv
// rtl/a5_pkg.sv - shared constants, register map and FSM states for the A5/1 key setup
package a5_pkg;

  // Register geometry, feedback tap masks and majority clocking bit positions
  localparam int R1_WIDTH = 19;
  localparam int R2_WIDTH = 22;
  localparam int R3_WIDTH = 23;

  localparam logic [R1_WIDTH-1:0] R1_TAPS = 19'h7_2000;   // bits 18,17,16,13
  localparam logic [R2_WIDTH-1:0] R2_TAPS = 22'h30_0000;  // bits 21,20
  localparam logic [R3_WIDTH-1:0] R3_TAPS = 23'h70_0080;  // bits 22,21,20,7

  localparam int R1_CLK_BIT = 8;
  localparam int R2_CLK_BIT = 10;
  localparam int R3_CLK_BIT = 10;

  // Key schedule phase lengths
  localparam int DEF_KEY_BITS   = 64;
  localparam int DEF_FRAME_BITS = 22;
  localparam int DEF_MIX_CYCLES = 100;

  // Word offsets (byte address bits [3:2])
  localparam logic [1:0] REG_KEY_LO = 2'd0;
  localparam logic [1:0] REG_KEY_HI = 2'd1;
  localparam logic [1:0] REG_FRAME  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KEY,
    ST_LOAD_FRAME,
    ST_MIX,
    ST_HANDOFF
  } ks_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a5_ks_lfsr.sv
// rtl/a5_ks_lfsr.sv - one A5/1 shift register with feedback taps and external bit injection
module a5_ks_lfsr #(
  parameter int               WIDTH   = 19,
  parameter logic [WIDTH-1:0] TAPS    = '0,
  parameter int               CLK_BIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step_en,
  input  logic             in_bit,
  output logic [WIDTH-1:0] state,
  output logic             clk_bit
);

  logic feedback;

  assign feedback = (^(state & TAPS)) ^ in_bit;
  assign clk_bit  = state[CLK_BIT];

  // Shift in the feedback bit on each enabled step; clear zeroes for a new schedule
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= '0;
    end else if (step_en) begin
      state <= {state[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/a5_key_setup.sv
// rtl/a5_key_setup.sv - Wishbone-programmed A5/1 key schedule with valid/ready state handoff
module a5_key_setup
  import a5_pkg::*;
#(
  parameter int MIX_CYCLES = DEF_MIX_CYCLES,
  parameter int KEY_BITS   = DEF_KEY_BITS,
  parameter int FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_dat_i,
  input  logic [31:0]         wbs_adr_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic                ld_valid,
  input  logic                ld_ready,
  output logic [R1_WIDTH-1:0] ld_r1,
  output logic [R2_WIDTH-1:0] ld_r2,
  output logic [R3_WIDTH-1:0] ld_r3
);

  localparam logic [7:0] KEY_LAST   = 8'(KEY_BITS - 1);
  localparam logic [7:0] FRAME_LAST = 8'(FRAME_BITS - 1);
  localparam logic [7:0] MIX_LAST   = 8'(MIX_CYCLES - 1);

  // Bus side
  logic        access;
  logic        req_we;
  logic [1:0]  req_reg;
  logic [31:0] req_dat;
  logic [31:0] rd_word;
  logic        wr_cycle;
  logic        cfg_wr;
  logic        start_go;

  // Programmed values and status
  logic [63:0] key_q;
  logic [21:0] frame_q;
  logic        done_q;
  logic        busy;

  // Schedule control
  ks_state_t   state_q;
  ks_state_t   state_d;
  logic [7:0]  step_cnt;
  logic        load_step;
  logic        mix_step;
  logic        in_bit;
  logic        maj;

  // Register bank
  logic [R1_WIDTH-1:0] r1_state;
  logic [R2_WIDTH-1:0] r2_state;
  logic [R3_WIDTH-1:0] r3_state;
  logic                r1_clk;
  logic                r2_clk;
  logic                r3_clk;
  logic                r1_en;
  logic                r2_en;
  logic                r3_en;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

  assign access = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign busy   = (state_q != ST_IDLE);

  // Writes take effect in the ack cycle so the schedule starts the cycle after the ack
  assign wr_cycle = wbs_ack_o & req_we;
  assign cfg_wr   = wr_cycle & ~busy;
  assign start_go = cfg_wr & (req_reg == REG_CTRL) & req_dat[0];

  // Read mux, decoded from the live address during the access cycle
  always_comb begin
    rd_word = '0;
    case (wbs_adr_i[3:2])
      REG_KEY_LO: rd_word = key_q[31:0];
      REG_KEY_HI: rd_word = key_q[63:32];
      REG_FRAME:  rd_word = {10'd0, frame_q};
      default:    rd_word = {30'd0, done_q, busy};
    endcase
  end

  // Single-cycle ack, read data presented only alongside ack, write request captured
  always_ff @(posedge clk) begin
    if (reset) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      req_we    <= 1'b0;
      req_reg   <= '0;
      req_dat   <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rd_word : '0;
      if (access) begin
        req_we  <= wbs_we_i;
        req_reg <= wbs_adr_i[3:2];
        req_dat <= wbs_dat_i;
      end else begin
        req_we  <= 1'b0;
      end
    end
  end

  // Key and frame registers; updates while busy are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q   <= '0;
      frame_q <= '0;
    end else if (cfg_wr) begin
      case (req_reg)
        REG_KEY_LO: key_q[31:0]  <= req_dat;
        REG_KEY_HI: key_q[63:32] <= req_dat;
        REG_FRAME:  frame_q      <= req_dat[21:0];
        default:    ;
      endcase
    end
  end

  // Sticky done: cleared by a new start, set when the generator takes the state
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else if (start_go) begin
      done_q <= 1'b0;
    end else if (state_q == ST_HANDOFF && ld_ready) begin
      done_q <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, input bit selection and step qualifiers
  always_comb begin
    state_d   = state_q;
    in_bit    = 1'b0;
    load_step = 1'b0;
    mix_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_go) state_d = ST_LOAD_KEY;
      end
      ST_LOAD_KEY: begin
        load_step = 1'b1;
        in_bit    = key_q[step_cnt[5:0]];
        if (step_cnt == KEY_LAST) state_d = ST_LOAD_FRAME;
      end
      ST_LOAD_FRAME: begin
        load_step = 1'b1;
        in_bit    = frame_q[step_cnt[4:0]];
        if (step_cnt == FRAME_LAST) state_d = ST_MIX;
      end
      ST_MIX: begin
        mix_step = 1'b1;
        if (step_cnt == MIX_LAST) state_d = ST_HANDOFF;
      end
      ST_HANDOFF: begin
        if (ld_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase step counter: restarts at every state change, only counts in stepping phases
  always_ff @(posedge clk) begin
    if (reset || (state_d != state_q)) begin
      step_cnt <= '0;
    end else if (load_step || mix_step) begin
      step_cnt <= step_cnt + 8'd1;
    end
  end

  // Majority clocking: in MIX a register steps only when its clock bit agrees with the vote
  assign maj   = majority3(r1_clk, r2_clk, r3_clk);
  assign r1_en = load_step | (mix_step & (r1_clk == maj));
  assign r2_en = load_step | (mix_step & (r2_clk == maj));
  assign r3_en = load_step | (mix_step & (r3_clk == maj));

  a5_ks_lfsr #(.WIDTH(R1_WIDTH), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK_BIT)) u_r1 (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_go),
    .step_en (r1_en),
    .in_bit  (in_bit),
    .state   (r1_state),
    .clk_bit (r1_clk)
  );

  a5_ks_lfsr #(.WIDTH(R2_WIDTH), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK_BIT)) u_r2 (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_go),
    .step_en (r2_en),
    .in_bit  (in_bit),
    .state   (r2_state),
    .clk_bit (r2_clk)
  );

  a5_ks_lfsr #(.WIDTH(R3_WIDTH), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK_BIT)) u_r3 (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_go),
    .step_en (r3_en),
    .in_bit  (in_bit),
    .state   (r3_state),
    .clk_bit (r3_clk)
  );

  assign ld_valid = (state_q == ST_HANDOFF);
  assign ld_r1    = r1_state;
  assign ld_r2    = r2_state;
  assign ld_r3    = r3_state;

endmodule
